// File: rtl/ide_arb_pkg.sv
// ============================================================================
// Module  : ide_arb_pkg
// Brief   : Shared types and widths for the two-client IDE block arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package ide_arb_pkg;

    localparam int LBA_W   = 24;
    localparam int BUF_AW  = 8;
    localparam int WORD_W  = 12;
    localparam int NCLIENT = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        REJECT  = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/ide_arb_pick.sv
// ============================================================================
// Module  : ide_arb_pick
// Brief   : Two-way grant picker. IDE_ARB_RR_EN selects round-robin on ties,
//           otherwise client 0 has fixed priority.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ide_arb_pick
    import ide_arb_pkg::*;
(
    input  logic [NCLIENT-1:0] i_req,
    input  logic               i_last_grant,
    output logic [NCLIENT-1:0] o_grant
);

`ifdef IDE_ARB_RR_EN
    // On a tie the client that was not served last wins.
    always_comb begin
        o_grant = i_req;
        if (i_req[0] && i_req[1]) begin
            o_grant = i_last_grant ? 2'b01 : 2'b10;
        end
    end
`else
    logic w_unused_last_grant;
    assign w_unused_last_grant = i_last_grant;

    always_comb begin
        o_grant = '0;
        if (i_req[0]) begin
            o_grant = 2'b01;
        end else if (i_req[1]) begin
            o_grant = 2'b10;
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/ide_arbiter.sv
// ============================================================================
// Module  : ide_arbiter
// Brief   : Shares one IDE block engine between two clients with per-client
//           partition offset/range check and buffer-port steering.
//           Define IDE_ARB_RR_EN for round-robin arbitration.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ide_arbiter
    import ide_arb_pkg::*;
#(
    parameter logic [LBA_W-1:0] C0_BASE   = 24'h000000,
    parameter logic [LBA_W-1:0] C1_BASE   = 24'h010000,
    parameter logic [LBA_W-1:0] PART_SIZE = 24'h010000
)(
    input  logic                clk,
    input  logic                reset,

    input  logic [LBA_W-1:0]    c0_lba,
    input  logic                c0_read_req,
    input  logic                c0_write_req,
    output logic                c0_done,
    output logic                c0_error,
    output logic [BUF_AW-1:0]   c0_buffer_addr,
    output logic                c0_buffer_rd,
    output logic                c0_buffer_wr,
    output logic [WORD_W-1:0]   c0_buffer_out,
    input  logic [WORD_W-1:0]   c0_buffer_in,

    input  logic [LBA_W-1:0]    c1_lba,
    input  logic                c1_read_req,
    input  logic                c1_write_req,
    output logic                c1_done,
    output logic                c1_error,
    output logic [BUF_AW-1:0]   c1_buffer_addr,
    output logic                c1_buffer_rd,
    output logic                c1_buffer_wr,
    output logic [WORD_W-1:0]   c1_buffer_out,
    input  logic [WORD_W-1:0]   c1_buffer_in,

    output logic [LBA_W-1:0]    ide_lba,
    output logic                ide_read_req,
    output logic                ide_write_req,
    input  logic                ide_done,
    input  logic                ide_error,
    input  logic [BUF_AW-1:0]   buffer_addr,
    input  logic                buffer_rd,
    input  logic                buffer_wr,
    input  logic [WORD_W-1:0]   buffer_out,
    output logic [WORD_W-1:0]   buffer_in
);

    arb_state_t          r_state_q, w_state_d;
    logic                r_gnt_q, w_gnt_d;
    logic [LBA_W-1:0]    r_ide_lba_q, w_ide_lba_d;
    logic                r_ide_rd_q, w_ide_rd_d;
    logic                r_ide_wr_q, w_ide_wr_d;
    logic [NCLIENT-1:0]  r_done_q, w_done_d;
    logic [NCLIENT-1:0]  r_error_q, w_error_d;

    logic [NCLIENT-1:0]  w_req;
    logic [NCLIENT-1:0]  w_pick;
    logic                w_pick_idx;
    logic                w_last_grant;
    logic [LBA_W-1:0]    w_sel_lba;
    logic [LBA_W-1:0]    w_sel_base;
    logic                w_sel_wr;
    logic                w_busy;

    assign w_req = {c1_read_req | c1_write_req, c0_read_req | c0_write_req};

`ifdef IDE_ARB_RR_EN
    logic r_last_grant_q, w_last_grant_d;
    assign w_last_grant = r_last_grant_q;
`else
    assign w_last_grant = 1'b1;
`endif

    ide_arb_pick u_pick (
        .i_req        (w_req),
        .i_last_grant (w_last_grant),
        .o_grant      (w_pick)
    );

    assign w_pick_idx = w_pick[1];
    assign w_sel_lba  = w_pick_idx ? c1_lba       : c0_lba;
    assign w_sel_base = w_pick_idx ? C1_BASE      : C0_BASE;
    assign w_sel_wr   = w_pick_idx ? c1_write_req : c0_write_req;

    always_comb begin
        w_state_d   = r_state_q;
        w_gnt_d     = r_gnt_q;
        w_ide_lba_d = r_ide_lba_q;
        w_ide_rd_d  = r_ide_rd_q;
        w_ide_wr_d  = r_ide_wr_q;
        w_done_d    = '0;
        w_error_d   = '0;
`ifdef IDE_ARB_RR_EN
        w_last_grant_d = r_last_grant_q;
`endif
        case (r_state_q)
            IDLE: begin
                if (|w_pick) begin
                    w_gnt_d = w_pick_idx;
`ifdef IDE_ARB_RR_EN
                    w_last_grant_d = w_pick_idx;
`endif
                    if (w_sel_lba >= PART_SIZE) begin
                        // Out-of-partition: answer in the next cycle, disk untouched.
                        w_done_d[w_pick_idx]  = 1'b1;
                        w_error_d[w_pick_idx] = 1'b1;
                        w_state_d             = REJECT;
                    end else begin
                        w_ide_lba_d = w_sel_lba + w_sel_base;
                        w_ide_wr_d  = w_sel_wr;
                        w_ide_rd_d  = ~w_sel_wr;
                        w_state_d   = BUSY;
                    end
                end
            end
            BUSY: begin
                if (ide_done) begin
                    w_ide_rd_d          = 1'b0;
                    w_ide_wr_d          = 1'b0;
                    w_done_d[r_gnt_q]   = 1'b1;
                    w_error_d[r_gnt_q]  = ide_error;
                    w_state_d           = RELEASE;
                end
            end
            REJECT: begin
                w_state_d = RELEASE;
            end
            RELEASE: begin
                // Hold off until the served client withdraws, so it is not re-served.
                if (!w_req[r_gnt_q]) begin
                    w_state_d = IDLE;
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q   <= IDLE;
            r_gnt_q     <= 1'b0;
            r_ide_lba_q <= '0;
            r_ide_rd_q  <= 1'b0;
            r_ide_wr_q  <= 1'b0;
            r_done_q    <= '0;
            r_error_q   <= '0;
`ifdef IDE_ARB_RR_EN
            r_last_grant_q <= 1'b1;
`endif
        end else begin
            r_state_q   <= w_state_d;
            r_gnt_q     <= w_gnt_d;
            r_ide_lba_q <= w_ide_lba_d;
            r_ide_rd_q  <= w_ide_rd_d;
            r_ide_wr_q  <= w_ide_wr_d;
            r_done_q    <= w_done_d;
            r_error_q   <= w_error_d;
`ifdef IDE_ARB_RR_EN
            r_last_grant_q <= w_last_grant_d;
`endif
        end
    end

    assign ide_lba       = r_ide_lba_q;
    assign ide_read_req  = r_ide_rd_q;
    assign ide_write_req = r_ide_wr_q;
    assign c0_done       = r_done_q[0];
    assign c1_done       = r_done_q[1];
    assign c0_error      = r_error_q[0];
    assign c1_error      = r_error_q[1];

    // Buffer port steering is combinational so disk strobes see no extra latency.
    assign w_busy = (r_state_q == BUSY);

    assign c0_buffer_addr = (w_busy && !r_gnt_q) ? buffer_addr : '0;
    assign c0_buffer_rd   = w_busy && !r_gnt_q && buffer_rd;
    assign c0_buffer_wr   = w_busy && !r_gnt_q && buffer_wr;
    assign c1_buffer_addr = (w_busy && r_gnt_q) ? buffer_addr : '0;
    assign c1_buffer_rd   = w_busy && r_gnt_q && buffer_rd;
    assign c1_buffer_wr   = w_busy && r_gnt_q && buffer_wr;
    assign c0_buffer_out  = buffer_out;
    assign c1_buffer_out  = buffer_out;
    assign buffer_in      = !w_busy ? '0 : (r_gnt_q ? c1_buffer_in : c0_buffer_in);

endmodule

`default_nettype wire
